// File: rtl/aes_host_loader.sv
// Host-side sequencer for the byte-wide AES register port: load text/key/mode, start, read back.
// Define LOADER_TIMEOUT_EN to bound the WAIT_OK phase by TIMEOUT cycles and report out_err.
module aes_host_loader #(
   parameter int unsigned MIN_START = 64,
   parameter int unsigned TIMEOUT   = 4096
) (
   input  logic         CLK,
   input  logic         RSTB,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_text,
   input  logic [255:0] in_key,
   input  logic [1:0]   in_ksize,
   input  logic         in_enc,
   output logic [127:0] out_data,
   output logic         out_valid,
   output logic         out_err,
   input  logic         out_ready,
   output logic [5:0]   ADDR,
   output logic [7:0]   DIN,
   output logic         WR,
   output logic         START,
   input  logic         OK,
   input  logic [7:0]   DOUT
);

   localparam int unsigned HoldW = (MIN_START > 1) ? $clog2(MIN_START) : 1;

   typedef enum logic [2:0] {
      StIdle, StWrText, StWrKey, StWrCfg, StStartHold, StWaitOk, StRd, StDone
   } state_e;

   state_e             state;
   logic [127:0]       text_q;
   logic [255:0]       key_q;
   logic [1:0]         ksize_q;
   logic               enc_q;
   logic [5:0]         cnt;
   logic [HoldW-1:0]   hold_cnt;
   logic               ok_meta;
   logic               ok_s;
   logic [5:0]         key_last;
   logic [2:0]         ksize_code;

   assign in_ready = (state == StIdle);

   always_comb begin
      key_last   = 6'd15;
      ksize_code = 3'b011;
      case (ksize_q)
         2'd1: begin
            key_last   = 6'd23;
            ksize_code = 3'b101;
         end
         2'd2: begin
            key_last   = 6'd31;
            ksize_code = 3'b111;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTB) begin
      if (!RSTB) begin
         ok_meta <= 1'b0;
         ok_s    <= 1'b0;
      end else begin
         ok_meta <= OK;
         ok_s    <= ok_meta;
      end
   end

`ifdef LOADER_TIMEOUT_EN
   localparam logic [15:0] ToLast = 16'(TIMEOUT - 1);
   logic [15:0] to_cnt;
   logic        err_q;
   assign out_err = err_q;
`else
   assign out_err = 1'b0;
`endif

   always_ff @(posedge CLK or negedge RSTB) begin
      if (!RSTB) begin
         state     <= StIdle;
         text_q    <= '0;
         key_q     <= '0;
         ksize_q   <= '0;
         enc_q     <= 1'b0;
         cnt       <= '0;
         hold_cnt  <= '0;
         ADDR      <= '0;
         DIN       <= '0;
         WR        <= 1'b0;
         START     <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
`ifdef LOADER_TIMEOUT_EN
         to_cnt    <= '0;
         err_q     <= 1'b0;
`endif
      end else begin
         unique case (state)
            StIdle: begin
               if (in_valid && in_ready) begin
                  // Text and key are shifted out LSB-first, one byte per write cycle.
                  text_q  <= in_text >> 8;
                  key_q   <= in_key;
                  ksize_q <= in_ksize;
                  enc_q   <= in_enc;
                  WR      <= 1'b1;
                  ADDR    <= 6'h00;
                  DIN     <= in_text[7:0];
                  cnt     <= '0;
                  state   <= StWrText;
               end
            end
            StWrText: begin
               if (cnt == 6'd15) begin
                  ADDR  <= 6'h20;
                  DIN   <= key_q[7:0];
                  key_q <= key_q >> 8;
                  cnt   <= '0;
                  state <= StWrKey;
               end else begin
                  ADDR   <= ADDR + 6'd1;
                  DIN    <= text_q[7:0];
                  text_q <= text_q >> 8;
                  cnt    <= cnt + 6'd1;
               end
            end
            StWrKey: begin
               if (cnt == key_last) begin
                  ADDR  <= 6'h08;
                  DIN   <= {7'b0, enc_q};
                  state <= StWrCfg;
               end else begin
                  ADDR  <= ADDR + 6'd1;
                  DIN   <= key_q[7:0];
                  key_q <= key_q >> 8;
                  cnt   <= cnt + 6'd1;
               end
            end
            StWrCfg: begin
               if (ADDR == 6'h08) begin
                  ADDR <= 6'h09;
                  DIN  <= {5'b0, ksize_code};
               end else begin
                  WR       <= 1'b0;
                  ADDR     <= '0;
                  DIN      <= '0;
                  START    <= 1'b1;
                  hold_cnt <= HoldW'(MIN_START - 1);
                  state    <= StStartHold;
               end
            end
            StStartHold: begin
               // ok_s is ignored here so a stale OK from the last run cannot end this one.
               if (hold_cnt == '0) begin
                  state <= StWaitOk;
`ifdef LOADER_TIMEOUT_EN
                  to_cnt <= '0;
`endif
               end else begin
                  hold_cnt <= hold_cnt - HoldW'(1);
               end
            end
            StWaitOk: begin
               if (ok_s) begin
                  START <= 1'b0;
                  ADDR  <= 6'h10;
                  cnt   <= '0;
                  state <= StRd;
               end
`ifdef LOADER_TIMEOUT_EN
               else if (to_cnt == ToLast) begin
                  START     <= 1'b0;
                  out_valid <= 1'b1;
                  err_q     <= 1'b1;
                  state     <= StDone;
               end else begin
                  to_cnt <= to_cnt + 16'd1;
               end
`endif
            end
            StRd: begin
               // DOUT lags ADDR by one cycle; shifting in from the top leaves byte i at [8i+:8].
               if (cnt != '0) begin
                  out_data <= {DOUT, out_data[127:8]};
               end
               if (cnt == 6'd16) begin
                  ADDR      <= '0;
                  out_valid <= 1'b1;
`ifdef LOADER_TIMEOUT_EN
                  err_q     <= 1'b0;
`endif
                  state     <= StDone;
               end else begin
                  ADDR <= (cnt == 6'd15) ? 6'h00 : ADDR + 6'd1;
                  cnt  <= cnt + 6'd1;
               end
            end
            StDone: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: doc/aes_host_loader.md
# aes_host_loader

Host-side sequencer for the AES byte-wide register port: the master on the other end of the DIN/ADDR/WR/START/OK/DOUT bus. It accepts one 128-bit block, a key and a mode over a valid/ready handshake. It writes them byte by byte into the register file, raises START and waits for OK. It then reads the 16 result bytes back and presents them as one 128-bit word with valid/ready. It sits between the system bus or testbench and the AES IO register interface.

## Interface
- MIN_START, default 64: minimum number of CLK cycles START is held high before OK is trusted. Must cover at least 2 clk_slow periods.
- TIMEOUT, default 4096: maximum number of CLK cycles spent in WAIT_OK. Used only with the macro described under Configuration.
- CLK  in  1  system clock; all logic is on the rising edge.
- RSTB  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  high exactly when the FSM is in IDLE.
- in_text  in  128  input block; byte i is in_text[8i+7:8i].
- in_key  in  256  key; byte j is in_key[8j+7:8j]; unused upper bytes are ignored.
- in_ksize  in  2  key size: 0 = 128-bit, 1 = 192-bit, 2 = 256-bit, 3 = treated as 0.
- in_enc  in  1  1 = encrypt, 0 = decrypt.
- out_data  out  128  result; byte i is read from address 0x10+i.
- out_valid  out  1  result valid.
- out_err  out  1  timeout flag; valid while out_valid is high.
- out_ready  in  1  result accepted.
- ADDR  out  6  register address.
- DIN  out  8  write data.
- WR  out  1  write strobe; 1 = write, 0 = read.
- START  out  1  start request.
- OK  in  1  done flag from the slow domain; passed through a 2-flop synchronizer to give ok_s.
- DOUT  in  8  registered read data; valid on the cycle after ADDR is presented with WR=0.

## Operation
- Register map: text bytes at 0x00–0x0F, result bytes at 0x10–0x1F, key bytes at 0x20–0x3F, mode at 0x08 (DIN[0] = in_enc), key-size code at 0x09.
- Key-size code on DIN[2:0]: 3'b011 for 128-bit, 3'b101 for 192-bit, 3'b111 for 256-bit.
- Config is written last, so on addresses 0x08 and 0x09 the mode and key-size writes take effect.
- The handshake is accepted when in_valid && in_ready. All in_* inputs are captured into internal registers at that point.
- FSM states and transitions:
  - IDLE: waits for an accepted request, then goes to WR_TEXT.
  - WR_TEXT: 16 cycles, WR=1, ADDR 0x00..0x0F, DIN = text byte.
  - WR_KEY: NB cycles, where NB = 16/24/32 for in_ksize 0/1/2. ADDR runs 0x20..0x20+NB-1.
  - WR_CFG: 2 cycles. Writes 0x08 (mode), then 0x09 (key-size code).
  - START_HOLD: WR=0, START=1, for MIN_START cycles counted by a down-counter.
  - WAIT_OK: START stays 1 until ok_s=1.
  - RD: 17 cycles. ADDR 0x10..0x1F is issued on cycles 0–15; the DOUT byte for address 0x10+i is captured on cycle i+1 into out_data byte i. START=0 throughout RD.
  - DONE: out_valid=1, held until out_ready, then back to IDLE.
- out_data and out_err hold their values until the next capture.
- Outside the write states, WR=0 and DIN=0.

## Timing
- Reset values: ADDR=0, DIN=0, WR=0, START=0, out_valid=0, out_err=0, out_data=0, FSM in IDLE. Because in_ready is derived from IDLE, in_ready=1 during and after reset.
- An RSTB assertion in mid-operation aborts immediately to the reset state. No partial result is emitted.
- The first write is driven on the cycle after the handshake.
- Write phase length is 34, 42 or 50 cycles for 128-, 192- and 256-bit keys.
- Best-case total latency, from handshake to out_valid: writes + MIN_START + 2 synchronizer cycles + 17 read cycles + 1.
- out_valid and out_ready high in the same cycle completes the handshake. in_ready rises on the next cycle.
- A new request may not overlap the current one; in_valid is ignored outside IDLE.
- A stale OK=1 from the previous operation is tolerated, because START_HOLD masks ok_s for MIN_START cycles.

## Configuration
- LOADER_TIMEOUT_EN defined:
  - A 16-bit counter runs in WAIT_OK.
  - When it reaches TIMEOUT, the FSM drops START and goes directly to DONE with out_err=1, leaving out_data unchanged.
  - Otherwise out_err=0.
- LOADER_TIMEOUT_EN undefined:
  - WAIT_OK waits indefinitely.
  - out_err is tied to 0.

## Test plan
- After reset, check in_ready=1, WR=0, START=0, out_valid=0. Then send a 128-bit request with in_key=000102..0F, text=00112233..FF and in_enc=1. Required: 34 write cycles, with address 0x20 carrying DIN=0x00, 0x08 carrying DIN=0x01, and 0x09 carrying DIN=0x03.
- With ksize=2, check 32 key writes ending at ADDR 0x3F and 0x09 written with DIN=0x07. With ksize=3, check 16 key writes and DIN=0x03.
- Register-file model with OK rising 200 cycles after START: START stays high until ok_s=1. The model drives result bytes 0x10+i = 0xA0+i; required out_data byte i = 0xA0+i and out_err=0.
- Hold out_ready=0 for 10 cycles: out_valid and out_data stay stable and in_ready stays 0. A request presented on in_valid during this time is not accepted.
- With LOADER_TIMEOUT_EN defined, TIMEOUT=100 and OK held at 0: START falls after 100 cycles in WAIT_OK, and out_valid=1 with out_err=1.
- Pulse RSTB low during WR_KEY and during WAIT_OK: all outputs return to their reset values on the same edge, and a following request completes normally.
